// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - LCD controller bus addresses, command opcodes and copier state encoding.
package lcd_pkg;

    localparam logic [23:0] LCD_CMD_ADDR   = 24'h0020FE;
    localparam logic [23:0] LCD_DATA_ADDR  = 24'h0020FF;
    localparam logic [7:0]  LCD_CMD_PAGE   = 8'hB0;
    localparam logic [7:0]  LCD_CMD_COL_LO = 8'h00;
    localparam logic [7:0]  LCD_CMD_COL_HI = 8'h10;
    localparam int          LCD_COLUMNS    = 132;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CMD,
        CMD_GAP,
        FETCH,
        DATA,
        DATA_GAP,
        DONE
    } copier_state_t;

endpackage

// File: rtl/lcd_frame_copier.sv
// rtl/lcd_frame_copier.sv - bus-master copying a 1bpp framebuffer into LCD display RAM page by page.
// Optional LCD_COPY_CLEAR_EN adds a clear input that blanks the LCD instead of copying.
module lcd_frame_copier
    import lcd_pkg::*;
#(
    parameter logic [23:0] FB_BASE    = 24'h001000,
    parameter int          COLS       = 96,
    parameter int          PAGES      = 8,
    parameter int          COL_OFFSET = 0
) (
    input  logic        clk,
    input  logic        reset_n,
`ifdef LCD_COPY_CLEAR_EN
    input  logic        clear,
`endif
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [23:0] fb_addr,
    output logic        fb_rd,
    input  logic [7:0]  fb_rdata,
    output logic [23:0] address_out,
    output logic [7:0]  data_out,
    output logic        bus_write
);

    localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [7:0] COL_OFF8 = COL_OFFSET[7:0];

    copier_state_t state;
    logic [PW-1:0] page;
    logic [CW-1:0] col;
    logic [1:0]    cmd_idx;
    logic [7:0]    hold;
    logic          fresh;
    logic          clear_r;
    logic          clear_in;
    logic [7:0]    cmd_byte;

`ifdef LCD_COPY_CLEAR_EN
    assign clear_in = clear;
`else
    assign clear_in = 1'b0;
`endif

    always_comb begin
        case (cmd_idx)
            2'd0:    cmd_byte = LCD_CMD_PAGE | 8'(page);
            2'd1:    cmd_byte = LCD_CMD_COL_LO | {4'h0, COL_OFF8[3:0]};
            default: cmd_byte = LCD_CMD_COL_HI | {4'h0, COL_OFF8[7:4]};
        endcase
    end

    // Strobes follow bus_ack combinationally so a write never lands in an ungranted cycle.
    always_comb begin
        address_out = '0;
        data_out    = '0;
        bus_write   = 1'b0;
        fb_rd       = 1'b0;
        fb_addr     = '0;
        case (state)
            CMD: begin
                address_out = LCD_CMD_ADDR;
                data_out    = cmd_byte;
                bus_write   = bus_ack;
            end
            FETCH: begin
                fb_rd   = !clear_r;
                fb_addr = FB_BASE + 24'(page) * 24'(COLS) + 24'(col);
            end
            DATA: begin
                address_out = LCD_DATA_ADDR;
                data_out    = clear_r ? 8'h00 : (fresh ? fb_rdata : hold);
                bus_write   = bus_ack;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE) && (state != DONE);
    assign bus_req = busy;
    assign done    = (state == DONE);

    // fb_rdata arrives in the first DATA cycle; hold keeps it while the grant is withheld.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            page    <= '0;
            col     <= '0;
            cmd_idx <= '0;
            hold    <= '0;
            fresh   <= 1'b0;
            clear_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= REQ;
                    page    <= '0;
                    col     <= '0;
                    cmd_idx <= '0;
                    clear_r <= clear_in;
                end
                REQ: if (bus_ack) state <= CMD;
                CMD: if (bus_ack) state <= CMD_GAP;
                CMD_GAP: begin
                    if (cmd_idx < 2'd2) begin
                        cmd_idx <= cmd_idx + 2'd1;
                        state   <= CMD;
                    end else begin
                        col   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    fresh <= 1'b1;
                    state <= DATA;
                end
                DATA: begin
                    if (fresh) begin
                        hold  <= fb_rdata;
                        fresh <= 1'b0;
                    end
                    if (bus_ack) state <= DATA_GAP;
                end
                DATA_GAP: begin
                    if (int'(col) < COLS - 1) begin
                        col   <= col + 1'b1;
                        state <= FETCH;
                    end else if (int'(page) < PAGES - 1) begin
                        page    <= page + 1'b1;
                        cmd_idx <= '0;
                        state   <= CMD;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_copier.sv
// tb/tb_lcd_frame_copier.sv - scoreboard bench for lcd_frame_copier (clear tests under LCD_COPY_CLEAR_EN).
module tb_lcd_frame_copier;

    localparam logic [23:0] FB_BASE  = 24'h001000;
    localparam int          COLS     = 96;
    localparam int          PAGES    = 8;
    localparam int          FRAME_CY = 2354;
    localparam int          FRAME_WR = 792;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, bus_req, bus_ack, fb_rd, bus_write;
    logic [23:0] fb_addr, address_out;
    logic [7:0]  fb_rdata, data_out;
`ifdef LCD_COPY_CLEAR_EN
    logic        clear = 1'b0;
`endif

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int writes = 0;
    int done_count = 0;
    int done_cyc = 0;
    bit prev_wr = 1'b0;
    bit drop_active = 1'b0;
    bit clear_mode = 1'b0;
    logic [23:0] log_a [0:1023];
    logic [7:0]  log_d [0:1023];
    logic [23:0] st_a;
    logic [7:0]  st_d;

    lcd_frame_copier #(
        .FB_BASE(FB_BASE), .COLS(COLS), .PAGES(PAGES), .COL_OFFSET(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef LCD_COPY_CLEAR_EN
        .clear(clear),
`endif
        .start(start),
        .busy(busy),
        .done(done),
        .bus_req(bus_req),
        .bus_ack(bus_ack),
        .fb_addr(fb_addr),
        .fb_rd(fb_rd),
        .fb_rdata(fb_rdata),
        .address_out(address_out),
        .data_out(data_out),
        .bus_write(bus_write)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (fb_rd) fb_rdata <= 8'(fb_addr - FB_BASE);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input bit clr);
        wr_t w;
        for (int p = 0; p < PAGES; p++) begin
            w.a = 24'h0020FE;
            w.d = 8'hB0 | 8'(p); exp_q.push_back(w);
            w.d = 8'h00;         exp_q.push_back(w);
            w.d = 8'h10;         exp_q.push_back(w);
            w.a = 24'h0020FF;
            for (int c = 0; c < COLS; c++) begin
                w.d = clr ? 8'h00 : 8'((p * COLS + c) % 256);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic goto_cycle(input int k);
        while (cyc != t0 + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_frame(input bit clr);
        exp_q.delete();
        push_frame(clr);
        writes     = 0;
        done_count = 0;
        clear_mode = clr;
`ifdef LCD_COPY_CLEAR_EN
        clear = clr;
`endif
        @(posedge clk);
        #1 start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc);
        int n = 0;
        while (done_count == 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_count"}, done_count, 1);
        check({tag, "_done_cycle"}, done_cyc, exp_cyc);
        check({tag, "_writes"}, writes, FRAME_WR);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        bus_ack = 1'b1;

        fork
            forever begin
                @(negedge clk);
                if (bus_write) begin
                    wr_t w;
                    check("strobe_gap", prev_wr, 0);
                    check("queue_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        w = exp_q.pop_front();
                        check("wr_addr", address_out, w.a);
                        check("wr_data", data_out, w.d);
                    end
                    if (writes < 1024) begin
                        log_a[writes] = address_out;
                        log_d[writes] = data_out;
                    end
                    writes++;
                    st_a = address_out;
                    st_d = data_out;
                end
                prev_wr = bus_write;
                if (drop_active) check("drop_quiet", {bus_write, fb_rd}, 0);
`ifdef LCD_COPY_CLEAR_EN
                if (clear_mode) check("clear_no_fb_rd", fb_rd, 0);
`endif
                if (done) begin
                    done_count++;
                    done_cyc = cyc - t0;
                end
            end
            forever begin
                @(posedge clk);
                if (prev_wr) begin
                    check("addr_stable", address_out, st_a);
                    check("data_stable", data_out, st_d);
                end
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_done", done, 0);
        check("rst_bus_write", bus_write, 0);
        check("rst_fb_rd", fb_rd, 0);
        check("rst_address", address_out, 0);
        reset_n = 1'b1;

        // Full frame, grant held
        start_frame(1'b0);
        wait_done("t1", FRAME_CY);
        check("t1_p3_cmd_addr", log_a[297], 24'h0020FE);
        check("t1_p3_page", log_d[297], 8'hB3);
        check("t1_p3_col_lo", log_d[298], 8'h00);
        check("t1_p3_col_hi", log_d[299], 8'h10);
        check("t1_p3_data_addr", log_a[300], 24'h0020FF);
        check("t1_p3_first", log_d[300], 8'h20);
        check("t1_p3_last", log_d[395], 8'h7F);

        // Grant withdrawn for 5 cycles during page 2 data
        start_frame(1'b0);
        goto_cycle(627);
        bus_ack     = 1'b0;
        drop_active = 1'b1;
        check("t2_req_held", bus_req, 1);
        goto_cycle(632);
        check("t2_req_still_held", bus_req, 1);
        bus_ack     = 1'b1;
        drop_active = 1'b0;
        wait_done("t2", FRAME_CY + 5);

        // start re-pulsed while busy and in the DONE cycle
        start_frame(1'b0);
        goto_cycle(100);
        start = 1'b1;
        goto_cycle(101);
        start = 1'b0;
        goto_cycle(FRAME_CY);
        check("t3_done_now", done, 1);
        start = 1'b1;
        goto_cycle(FRAME_CY + 1);
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t3_done_count", done_count, 1);
        check("t3_done_cycle", done_cyc, FRAME_CY);
        check("t3_writes", writes, FRAME_WR);
        check("t3_busy", busy, 0);

        // Asynchronous reset mid-frame
        start_frame(1'b0);
        goto_cycle(500);
        check("t4_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check("t4_bus_write", bus_write, 0);
        check("t4_bus_req", bus_req, 0);
        check("t4_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        start_frame(1'b0);
        wait_done("t4", FRAME_CY);
        check("t4_first_addr", log_a[0], 24'h0020FE);
        check("t4_first_page", log_d[0], 8'hB0);

`ifdef LCD_COPY_CLEAR_EN
        // Clear frame
        start_frame(1'b1);
        wait_done("t6", FRAME_CY);
        check("t6_p3_page", log_d[297], 8'hB3);
        check("t6_data_zero", log_d[300], 8'h00);
        clear_mode = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
